// File: rtl/led_scan_ctrl.sv
// Multiplexed 8-digit LED scan controller. Each digit slot starts with a dark
// gap, then drives one digit. New content is swapped in only at frame boundaries.
module led_scan_ctrl #(
  parameter int DIV_MAX = 50000,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  output logic        ready,
  output logic [4:0]  seg_ctrl,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int TW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV_MAX - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    idx;
  logic [31:0]   act_data;
  logic [31:0]   pend_data;
  logic [7:0]    act_dp;
  logic [7:0]    pend_dp;

  logic          boundary;
  logic          transfer;
  logic [2:0]    next_idx;
  logic [31:0]   next_data;
  logic [7:0]    next_dp;
  logic [7:0]    digit_an;

  function automatic logic [4:0] seg_of(input logic [31:0] d, input logic [7:0] p,
                                        input logic [2:0] i);
    return {p[i], d[{i, 2'b00} +: 4]};
  endfunction

  // ready=0 doubles as the "pending load present" flag
  assign boundary  = en && (state == SHOW) && (idx == 3'd7) && (tick == TICK_LAST);
  assign transfer  = boundary && !ready;
  assign next_idx  = idx + 3'd1;
  assign next_data = transfer ? pend_data : act_data;
  assign next_dp   = transfer ? pend_dp   : act_dp;
  assign digit_an  = blank_in[idx] ? 8'hFF : ~(8'b1 << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      idx        <= '0;
      an         <= 8'hFF;
      seg_ctrl   <= 5'h00;
      ready      <= 1'b1;
      frame_done <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
    end else begin
      frame_done <= boundary;

      // A load taken on the boundary cycle itself waits for the next boundary
      if (transfer) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        ready    <= 1'b1;
      end else if (load && ready) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        ready     <= 1'b0;
      end

      if (!en) begin
        state <= IDLE;
        tick  <= '0;
        idx   <= '0;
        an    <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            state    <= GAP;
            tick     <= '0;
            idx      <= '0;
            an       <= 8'hFF;
            seg_ctrl <= seg_of(act_data, act_dp, 3'd0);
          end
          GAP: begin
            tick <= tick + 1'b1;
            if (tick == GAP_LAST) begin
              state <= SHOW;
              an    <= digit_an;
            end else begin
              an <= 8'hFF;
            end
          end
          SHOW: begin
            if (tick == TICK_LAST) begin
              state    <= GAP;
              tick     <= '0;
              idx      <= next_idx;
              an       <= 8'hFF;
              seg_ctrl <= seg_of(next_data, next_dp, next_idx);
            end else begin
              tick <= tick + 1'b1;
              an   <= digit_an;
            end
          end
          default: begin
            state <= IDLE;
            tick  <= '0;
            idx   <= '0;
            an    <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: a timeline model predicts each cycle's
// outputs from position-in-frame arithmetic; a monitor pops and compares.
module tb_led_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GAP   = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        ready;
  logic [4:0]  seg_ctrl;
  logic [7:0]  an;
  logic        frame_done;

  led_scan_ctrl #(.DIV_MAX(DIV), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .ready(ready), .seg_ctrl(seg_ctrl),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [4:0] seg;
    logic [7:0] an;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: position n within the running frame, plus content registers
  bit          m_run;
  int          m_n;
  logic [31:0] m_act_data, m_pend_data;
  logic [7:0]  m_act_dp, m_pend_dp;
  bit          m_pend;
  exp_t        m_exp;

  function automatic void modelReset();
    m_run = 0; m_n = 0; m_pend = 0;
    m_act_data = '0; m_act_dp = '0; m_pend_data = '0; m_pend_dp = '0;
    m_exp = '{rdy: 1'b1, seg: 5'h00, an: 8'hFF, fd: 1'b0};
  endfunction

  function automatic void modelStep();
    bit boundary;
    int pos, digit;
    boundary = m_run && en && (m_n == FRAME - 1);
    if (boundary && m_pend) begin
      m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_pend = 0;
    end else if (load && !m_pend) begin
      m_pend_data = data_in; m_pend_dp = dp_in; m_pend = 1;
    end
    if (!en) begin
      m_run = 0; m_n = 0;
    end else if (!m_run) begin
      m_run = 1; m_n = 0;
    end else begin
      m_n = (m_n + 1) % FRAME;
    end
    m_exp.fd  = boundary;
    m_exp.rdy = !m_pend;
    if (m_run) begin
      pos   = m_n % DIV;
      digit = m_n / DIV;
      m_exp.an  = (pos < GAP || blank_in[digit]) ? 8'hFF : ~(8'(1) << digit);
      m_exp.seg = {m_act_dp[digit], m_act_data[digit*4 +: 4]};
    end else begin
      m_exp.an = 8'hFF;
    end
  endfunction

  task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("ready", {7'd0, ready}, {7'd0, e.rdy});
    checkField("seg_ctrl", {3'd0, seg_ctrl}, {3'd0, e.seg});
    checkField("an", an, e.an);
    checkField("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Called at posedge+1; inputs are sampled by the DUT at the next posedge
  task automatic applyStimulus(input logic e, input logic l, input logic [31:0] d,
                               input logic [7:0] p, input logic [7:0] b);
    en = e; load = l; data_in = d; dp_in = p; blank_in = b;
    modelStep();
    @(posedge clk);
    #1;
    exp_q.push_back(m_exp);
  endtask

  task automatic doReset();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    rst_n = 1'b0;
    load  = 1'b0;
    modelReset();
    #1;
    exp_q.push_back(m_exp);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runCycles(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, $urandom, 8'($urandom), b);
  endtask

  task automatic advanceTo(input int target, input logic [7:0] b);
    int i;
    for (i = 0; i < 3 * FRAME && !(m_run && m_n == target); i++)
      applyStimulus(1'b1, 1'b0, $urandom, 8'($urandom), b);
    if (!(m_run && m_n == target)) begin
      total++;
      bad++;
      $display("[TB] FAIL advance: got position %0d expected %0d", m_n, target);
    end
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    doReset();

    // Basic load and scan of 0x76543210
    applyStimulus(1'b1, 1'b1, 32'h76543210, 8'h00, 8'h00);
    runCycles(3 * FRAME + 5, 8'h00);

    // Decimal points and blanked digit 2
    applyStimulus(1'b1, 1'b1, 32'hFEDCBA98, 8'h81, 8'h04);
    runCycles(2 * FRAME + 10, 8'h04);

    // Second load while one is pending must be ignored
    advanceTo(20, 8'h00);
    applyStimulus(1'b1, 1'b1, 32'h11111111, 8'h00, 8'h00);
    runCycles(5, 8'h00);
    applyStimulus(1'b1, 1'b1, 32'h22222222, 8'hFF, 8'h00);
    runCycles(2 * FRAME, 8'h00);

    // Load exactly on the boundary cycle
    advanceTo(FRAME - 1, 8'h00);
    applyStimulus(1'b1, 1'b1, 32'h33333333, 8'h55, 8'h00);
    runCycles(2 * FRAME + 3, 8'h00);

    // Drop en during SHOW of digit 5, then re-enable
    advanceTo(5 * DIV + 4, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, $urandom, 8'h00, 8'h00);
    runCycles(FRAME + 6, 8'h00);

    // Reset mid-SHOW with a pending load
    advanceTo(10, 8'h00);
    applyStimulus(1'b1, 1'b1, 32'h44444444, 8'hF0, 8'h00);
    advanceTo(3 * DIV + 5, 8'h00);
    doReset();
    runCycles(2 * FRAME + 2, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      else applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
                         $urandom, 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 50000: clock cycles per digit slot (gap plus show); SHALL be >= GAP_CYC+1.
REQ-002 Parameter GAP_CYC, default 16: all-digits-off dead cycles at the start of each slot; SHALL be >= 1.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 en  in  1  scan enable; 0 forces display off.
REQ-006 load  in  1  request to latch new display content; accepted only when ready=1.
REQ-007 data_in  in  32  eight hex nibbles; digit k = data_in[4k+3:4k].
REQ-008 dp_in  in  8  decimal point per digit; bit k = digit k.
REQ-009 blank_in  in  8  per-digit blank mask; sampled live each cycle, not via load.
REQ-010 ready  out  1  1 = no pending load; load accepted this cycle.
REQ-011 seg_ctrl  out  5  to the 7-segment decoder: {dp, hex nibble} of the current digit.
REQ-012 an  out  8  active-low digit enables; bit k drives digit k.
REQ-013 frame_done  out  1  one-cycle pulse after the last slot of every frame.

Function
REQ-014 States IDLE, GAP and SHOW, plus counters tick (0..DIV_MAX-1) and idx (0..7); all outputs registered.
REQ-015 IDLE: an=8'hFF, tick=0, idx=0; en=1 -> GAP next cycle.
REQ-016 GAP: an=8'hFF, tick increments; tick==GAP_CYC-1 -> SHOW next cycle.
REQ-017 SHOW: an=~(8'b1<<idx), or 8'hFF if blank_in[idx]=1; tick increments.
REQ-018 SHOW exit: when tick==DIV_MAX-1 -> tick=0, idx=idx+1 with 7 wrapping to 0, GAP next cycle.
REQ-019 Slot length: exactly GAP_CYC cycles of an=FF followed by DIV_MAX-GAP_CYC cycles of the selected digit; frame = 8*DIV_MAX cycles.
REQ-020 seg_ctrl update: loaded on every entry to GAP with {active_dp[new idx], active_data nibble[new idx]}; held constant through GAP and SHOW.
REQ-021 en=0 in any state -> IDLE next cycle (tick=0, idx=0, an=FF); seg_ctrl holds its last value.
REQ-022 Load acceptance: load=1 with ready=1 captures data_in/dp_in into pending registers; ready=0 from the next cycle.
REQ-023 load=1 with ready=0 is ignored; pending content is unchanged.
REQ-024 Frame boundary: the cycle with SHOW, idx==7, tick==DIV_MAX-1.
REQ-025 At a frame boundary with a pending load: pending copies to active, and ready=1 next cycle.
REQ-026 Digit-0 seg_ctrl of the new frame SHALL reflect the newly transferred content.
REQ-027 A load accepted on the frame-boundary cycle itself is transferred at the following boundary, not the current one.
REQ-028 frame_done=1 for exactly the cycle after each frame boundary; it never asserts in IDLE.
REQ-029 A pending load persists across en=0.
REQ-030 On en=0 -> IDLE, active content is retained; re-enable restarts at digit 0 with a GAP slot.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, tick=0, idx=0, an=8'hFF, seg_ctrl=5'h00, ready=1, frame_done=0.
REQ-032 rst_n=0 SHALL clear active and pending data/dp to 0; no transfer occurs across reset.
REQ-033 Reset asserted mid-slot or mid-pending-load discards all progress and the pending load.
REQ-034 Release of rst_n is synchronous to clk; the first GAP follows one cycle after release if en=1.

Verification (DIV_MAX=8, GAP_CYC=2)
REQ-035 Reset, then load 0x76543210 / dp 0x00, en=1 -> ready=0 until the first frame_done; from the next frame, digit k shows 2 cycles an=FF then 6 cycles an=~(1<<k) with seg_ctrl=k; frame_done every 64 cycles.
REQ-036 Active content 0xFEDCBA98 / dp 0x81, blank_in=0x04 -> seg_ctrl 0x18 (digit 0) and 0x1F (digit 7); an stays FF during the digit-2 slot while seg_ctrl=0x0A.
REQ-037 load 0x11111111 at mid-frame, then load 0x22222222 while ready=0 -> second load ignored; next frame shows 1s; ready=1 the cycle after the boundary.
REQ-038 load asserted exactly on the boundary cycle -> current new frame unchanged; content appears one frame later; frame_done pulses unaffected.
REQ-039 en dropped during SHOW of digit 5 -> an=FF next cycle; re-assert -> GAP of digit 0 one cycle later with the same active content.
REQ-040 rst_n pulsed low mid-SHOW with a load pending -> an=FF, ready=1, seg_ctrl=0 immediately; after release all digits show 0.
